// File: rtl/sync_pkg.sv
// Shared types and defaults for the shot sequencer.
//   state_t            : sequencer state encoding, also driven out on state_code
//   CNT_W              : width of the single delay/timeout counter
//   *_DEF              : default delays and pulse width, in CLOCK_50 cycles
//   is_active()        : true for every state that counts as a shot in progress
package sync_pkg;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ARMED        = 3'd1,
        S_FG_WAIT_DLY  = 3'd2,
        S_DETONATE     = 3'd3,
        S_WIRE_WAIT    = 3'd4,
        S_DET_WAIT_DLY = 3'd5,
        S_DET_PULSE    = 3'd6,
        S_FAULT        = 3'd7
    } state_t;

    localparam int CNT_W = 32;

    localparam logic [CNT_W-1:0] FG_DELAY_DEF       = 32'd10_000_000;
    localparam logic [CNT_W-1:0] DETECTOR_DELAY_DEF = 32'd5;
    localparam logic [CNT_W-1:0] WIRE_TIMEOUT_DEF   = 32'd350_000;
    localparam logic [CNT_W-1:0] PULSE_W_DEF        = 32'd50;

    function automatic logic is_active(input state_t s);
        return (s != S_IDLE) && (s != S_FAULT);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   async_in : asynchronous level input
//   rise     : one-cycle strobe, high 3 cycles after async_in rises
module edge_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic       s_meta;
    logic       s_sync;
    logic       s_prev;
    logic [2:0] vld;

    // vld tracks how far real samples have travelled down the pipe after
    // reset; the detector only fires once s_prev holds a genuine sample, so an
    // input that was already high during reset is not mistaken for an edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_prev <= 1'b0;
            vld    <= 3'b000;
            rise   <= 1'b0;
        end else begin
            s_meta <= async_in;
            s_sync <= s_meta;
            s_prev <= s_sync;
            vld    <= {vld[1:0], 1'b1};
            rise   <= s_sync & ~s_prev & vld[2];
        end
    end

endmodule

// File: rtl/shot_sequencer.sv
// Sequences one shot: arm, wait FG_DELAY after the function-generator edge,
// fire the detonation pulse, wait for the wire trigger (with timeout), wait
// DETECTOR_DELAY, fire the detector pulse, then report done.
//   CLOCK_50          : 50 MHz system clock
//   reset             : synchronous, active-high
//   start_signal      : level, arms a shot from IDLE
//   abort_signal      : level, cancels a shot / clears FAULT (with start low)
//   fg_signal         : async function-generator input
//   wire_signal       : async wire-trigger input
//   detonation_signal : registered PULSE_W-cycle pulse
//   detector_signal   : registered PULSE_W-cycle pulse
//   busy              : high in every state except IDLE and FAULT
//   done              : one-cycle strobe on shot completion
//   fault             : high while in FAULT
//   state_code        : current state encoding
//
// state          | meaning
// ---------------+-----------------------------------------------
// IDLE           | waiting for start_signal
// ARMED          | waiting for fg_rise
// FG_WAIT_DLY    | counting FG_DELAY cycles
// DETONATE       | detonation pulse high for PULSE_W cycles
// WIRE_WAIT      | waiting for wire_rise, bounded by WIRE_TIMEOUT
// DET_WAIT_DLY   | counting DETECTOR_DELAY cycles
// DET_PULSE      | detector pulse high for PULSE_W cycles
// FAULT          | wire timeout; needs abort with start low to clear
module shot_sequencer
    import sync_pkg::*;
#(
    parameter logic [CNT_W-1:0] FG_DELAY       = FG_DELAY_DEF,
    parameter logic [CNT_W-1:0] DETECTOR_DELAY = DETECTOR_DELAY_DEF,
    parameter logic [CNT_W-1:0] WIRE_TIMEOUT   = WIRE_TIMEOUT_DEF,
    parameter logic [CNT_W-1:0] PULSE_W        = PULSE_W_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start_signal,
    input  logic       abort_signal,
    input  logic       fg_signal,
    input  logic       wire_signal,
    output logic       detonation_signal,
    output logic       detector_signal,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state_code
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             fg_rise;
    logic             wire_rise;

    edge_sync u_fg_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .async_in (fg_signal),
        .rise     (fg_rise)
    );

    edge_sync u_wire_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .async_in (wire_signal),
        .rise     (wire_rise)
    );

    assign state_code = state;

    // Each delay state occupies exactly its parameter's worth of cycles
    // (count 0..N-1). WIRE_WAIT compares against WIRE_TIMEOUT itself, so the
    // block sits there WIRE_TIMEOUT+1 cycles and wire_rise is still honoured
    // in the final cycle, where it is tested ahead of the timeout.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            detonation_signal <= 1'b0;
            detector_signal   <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            fault             <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_signal && is_active(state)) begin
                state             <= S_IDLE;
                cnt               <= '0;
                detonation_signal <= 1'b0;
                detector_signal   <= 1'b0;
                busy              <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_signal && !abort_signal) begin
                            state <= S_ARMED;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (fg_rise) begin
                            state <= S_FG_WAIT_DLY;
                            cnt   <= '0;
                        end
                    end
                    S_FG_WAIT_DLY: begin
                        if (cnt == FG_DELAY - 32'd1) begin
                            state             <= S_DETONATE;
                            cnt               <= '0;
                            detonation_signal <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_DETONATE: begin
                        if (cnt == PULSE_W - 32'd1) begin
                            state             <= S_WIRE_WAIT;
                            cnt               <= '0;
                            detonation_signal <= 1'b0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_WIRE_WAIT: begin
                        if (wire_rise) begin
                            state <= S_DET_WAIT_DLY;
                            cnt   <= '0;
                        end else if (cnt == WIRE_TIMEOUT) begin
                            state <= S_FAULT;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            fault <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_DET_WAIT_DLY: begin
                        if (cnt == DETECTOR_DELAY - 32'd1) begin
                            state           <= S_DET_PULSE;
                            cnt             <= '0;
                            detector_signal <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_DET_PULSE: begin
                        if (cnt == PULSE_W - 32'd1) begin
                            state           <= S_IDLE;
                            cnt             <= '0;
                            detector_signal <= 1'b0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_FAULT: begin
                        if (!start_signal && abort_signal) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                            fault <= 1'b0;
                        end
                    end
                    default: begin
                        state             <= S_IDLE;
                        cnt               <= '0;
                        detonation_signal <= 1'b0;
                        detector_signal   <= 1'b0;
                        busy              <= 1'b0;
                        fault             <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer with small delays. Expected output
// vectors are computed per cycle from event times (pin edges, start, abort,
// reset) using the documented latencies.
module tb_shot_sequencer;

    localparam int FG = 10;
    localparam int DD = 5;
    localparam int WT = 20;
    localparam int PW = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start_signal;
    logic       abort_signal;
    logic       fg_signal;
    logic       wire_signal;
    logic       detonation_signal;
    logic       detector_signal;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] state_code;

    int n_checks = 0;
    int n_pass   = 0;

    shot_sequencer #(
        .FG_DELAY       (FG),
        .DETECTOR_DELAY (DD),
        .WIRE_TIMEOUT   (WT),
        .PULSE_W        (PW)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .start_signal      (start_signal),
        .abort_signal      (abort_signal),
        .fg_signal         (fg_signal),
        .wire_signal       (wire_signal),
        .detonation_signal (detonation_signal),
        .detector_signal   (detector_signal),
        .busy              (busy),
        .done              (done),
        .fault             (fault),
        .state_code        (state_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Observed vector: {det, dtr, busy, done, fault, state_code[2:0]}
    function automatic logic [7:0] obs_vec();
        return {detonation_signal, detector_signal, busy, done, fault, state_code};
    endfunction

    function automatic logic [7:0] exp_vec(input logic [2:0] code, input logic dn);
        logic bz;
        bz = (code != 3'd0) && (code != 3'd7);
        return {code == 3'd3, code == 3'd6, bz, dn, code == 3'd7, code};
    endfunction

    // Expected state of one shot in cycle i: armed in cycle a, fg pin rises in
    // cycle p, wire pin rises in cycle q. Edge strobes land 3 cycles after the
    // pin; each delay state lasts its parameter value.
    function automatic logic [2:0] shot_code(input int i, input int a, input int p, input int q);
        int fr, d, f, wr, e, dc;
        fr = p + 3;
        d  = fr + FG + 1;
        f  = d + PW;
        wr = q + 3;
        e  = wr + DD + 1;
        dc = e + PW;
        if (i < a)   return 3'd0;
        if (i <= fr) return 3'd1;
        if (i < d)   return 3'd2;
        if (i < f)   return 3'd3;
        if (i <= wr) return 3'd4;
        if (i < e)   return 3'd5;
        if (i < dc)  return 3'd6;
        return 3'd0;
    endfunction

    task automatic next_cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        start_signal = 1'b0;
        abort_signal = 1'b0;
        fg_signal    = 1'b0;
        wire_signal  = 1'b0;
        repeat (3) next_cycle();
        reset = 1'b0;
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        logic [7:0] o;
        reset        = 1'b1;
        start_signal = 1'b1;
        abort_signal = 1'b0;
        fg_signal    = 1'b1;
        wire_signal  = 1'b1;
        repeat (3) next_cycle();
        @(negedge CLOCK_50);
        o = obs_vec();
        n_checks++;
        if (o !== 8'h00) $display("FAIL reset_hold: got %b want %b", o, 8'h00);
        else n_pass++;
        reset = 1'b0;
        // fg and wire already high during reset: no edge may be seen, so the
        // block sits in ARMED.
        for (int i = 1; i <= 30; i++) begin
            next_cycle();
            @(negedge CLOCK_50);
            o = obs_vec();
            n_checks++;
            if (o !== exp_vec(3'd1, 1'b0))
                $display("FAIL reset_no_false_edge cycle %0d: got %b want %b", i, o, exp_vec(3'd1, 1'b0));
            else n_pass++;
        end
        abort_signal = 1'b1;
        start_signal = 1'b0;
        next_cycle();
        @(negedge CLOCK_50);
        o = obs_vec();
        n_checks++;
        if (o !== 8'h00) $display("FAIL abort_from_armed: got %b want %b", o, 8'h00);
        else n_pass++;
        abort_signal = 1'b0;
        fg_signal    = 1'b0;
        wire_signal  = 1'b0;
        next_cycle();
    endtask

    task automatic test_shot(input int wire_off, input string tag);
        int p, fh, q, wh, f, dc;
        logic [7:0] o, e;
        p  = 1 + int'($urandom_range(0, 4));
        fh = 1 + int'($urandom_range(0, 6));
        f  = p + 3 + FG + 1 + PW;
        q  = f - 3 + wire_off;
        wh = 1 + int'($urandom_range(0, 5));
        dc = q + 3 + DD + 1 + PW;
        for (int i = 0; i <= dc + 3; i++) begin
            start_signal = (i < 2);
            fg_signal    = (i >= p) && (i < p + fh);
            wire_signal  = (i >= q) && (i < q + wh);
            @(negedge CLOCK_50);
            o = obs_vec();
            e = exp_vec(shot_code(i, 1, p, q), i == dc);
            n_checks++;
            if (o !== e) $display("FAIL %s cycle %0d: got %b want %b", tag, i, o, e);
            else n_pass++;
            next_cycle();
        end
        wire_signal = 1'b0;
        fg_signal   = 1'b0;
    endtask

    task automatic test_timeout();
        int p, d, f, t;
        logic [2:0] c;
        logic [7:0] o, e;
        p = 1 + int'($urandom_range(0, 4));
        d = p + 3 + FG + 1;
        f = d + PW;
        t = f + WT + 1;
        for (int i = 0; i <= t + 6; i++) begin
            start_signal = (i < 2) || ((i >= t + 1) && (i <= t + 3));
            abort_signal = (i >= t + 2) && (i <= t + 4);
            fg_signal    = (i >= p) && (i < p + 3);
            if (i < 1)           c = 3'd0;
            else if (i <= p + 3) c = 3'd1;
            else if (i < d)      c = 3'd2;
            else if (i < f)      c = 3'd3;
            else if (i < t)      c = 3'd4;
            else if (i <= t + 4) c = 3'd7;
            else                 c = 3'd0;
            @(negedge CLOCK_50);
            o = obs_vec();
            e = exp_vec(c, 1'b0);
            n_checks++;
            if (o !== e) $display("FAIL timeout cycle %0d: got %b want %b", i, o, e);
            else n_pass++;
            next_cycle();
        end
        start_signal = 1'b0;
        abort_signal = 1'b0;
    endtask

    task automatic test_abort();
        int p, d, ao, p2, last;
        logic [2:0] c;
        logic [7:0] o, e;
        p    = 1 + int'($urandom_range(0, 4));
        d    = p + 3 + FG + 1;
        ao   = int'($urandom_range(0, PW - 2));
        p2   = d + ao + 4;
        last = p2 + 3 + FG + PW + 6;
        for (int i = 0; i <= last; i++) begin
            start_signal = (i < 2);
            abort_signal = (i == d + ao);
            fg_signal    = ((i >= p) && (i < p + 3)) || ((i >= p2) && (i < p2 + 3));
            if (i < 1)            c = 3'd0;
            else if (i <= p + 3)  c = 3'd1;
            else if (i < d)       c = 3'd2;
            else if (i <= d + ao) c = 3'd3;
            else                  c = 3'd0;
            @(negedge CLOCK_50);
            o = obs_vec();
            e = exp_vec(c, 1'b0);
            n_checks++;
            if (o !== e) $display("FAIL abort_mid_pulse cycle %0d: got %b want %b", i, o, e);
            else n_pass++;
            next_cycle();
        end
        abort_signal = 1'b0;
        fg_signal    = 1'b0;
    endtask

    task automatic test_reset_mid_shot();
        int p, r, fl, a2, fr2, d2, f2, ab;
        logic [2:0] c;
        logic [7:0] o, e;
        p   = 1 + int'($urandom_range(0, 3));
        r   = p + 4 + int'($urandom_range(1, FG - 2));
        fl  = r + 18;
        a2  = r + 5;
        fr2 = fl + 7;
        d2  = fr2 + FG + 1;
        f2  = d2 + PW;
        ab  = f2 + 2;
        for (int i = 0; i <= ab + 4; i++) begin
            reset        = (i == r) || (i == r + 1);
            start_signal = (i < 2) || (i == r + 4) || (i == r + 5);
            abort_signal = (i == ab);
            fg_signal    = ((i >= p) && (i < fl)) || ((i >= fl + 4) && (i < fl + 7));
            if (i < 1)          c = 3'd0;
            else if (i <= p + 3) c = 3'd1;
            else if (i <= r)    c = 3'd2;
            else if (i < a2)    c = 3'd0;
            else if (i <= fr2)  c = 3'd1;
            else if (i < d2)    c = 3'd2;
            else if (i < f2)    c = 3'd3;
            else if (i <= ab)   c = 3'd4;
            else                c = 3'd0;
            @(negedge CLOCK_50);
            o = obs_vec();
            e = exp_vec(c, 1'b0);
            n_checks++;
            if (o !== e) $display("FAIL reset_mid_shot cycle %0d: got %b want %b", i, o, e);
            else n_pass++;
            next_cycle();
        end
        reset        = 1'b0;
        abort_signal = 1'b0;
        fg_signal    = 1'b0;
    endtask

    task automatic test_back_to_back();
        int p1, f1, q1, dc1, a2, p2, f2, q2, dc2, a3;
        logic [2:0] c;
        logic [7:0] o, e;
        p1  = 1 + int'($urandom_range(0, 3));
        f1  = p1 + 3 + FG + 1 + PW;
        q1  = f1 + 3 + int'($urandom_range(0, 4));
        dc1 = q1 + 3 + DD + 1 + PW;
        a2  = dc1 + 1;
        p2  = dc1 + 2 + int'($urandom_range(0, 3));
        f2  = p2 + 3 + FG + 1 + PW;
        q2  = f2 + 3 + int'($urandom_range(0, 4));
        dc2 = q2 + 3 + DD + 1 + PW;
        a3  = dc2 + 1;
        for (int i = 0; i <= dc2 + 3; i++) begin
            start_signal = 1'b1;
            // Extra fg edges land in WIRE_WAIT; an extra wire edge lands in
            // FG_WAIT_DLY of the first shot. None may disturb the sequence.
            fg_signal = ((i >= p1) && (i < p1 + 2)) ||
                        ((i >= f1 - 2) && (i < f1)) ||
                        ((i >= f1 + 1) && (i < f1 + 3)) ||
                        ((i >= p2) && (i < p2 + 2)) ||
                        ((i >= f2 + 1) && (i < f2 + 3));
            wire_signal = ((i >= p1 + 5) && (i < p1 + 7)) ||
                          ((i >= q1) && (i < q1 + 2)) ||
                          ((i >= q2) && (i < q2 + 2));
            if (i < a2)      c = shot_code(i, 1, p1, q1);
            else if (i < a3) c = shot_code(i, a2, p2, q2);
            else             c = 3'd1;
            @(negedge CLOCK_50);
            o = obs_vec();
            e = exp_vec(c, (i == dc1) || (i == dc2));
            n_checks++;
            if (o !== e) $display("FAIL back_to_back cycle %0d: got %b want %b", i, o, e);
            else n_pass++;
            next_cycle();
        end
        start_signal = 1'b0;
        abort_signal = 1'b1;
        fg_signal    = 1'b0;
        wire_signal  = 1'b0;
        next_cycle();
        abort_signal = 1'b0;
        next_cycle();
    endtask

    initial begin
        reset        = 1'b1;
        start_signal = 1'b0;
        abort_signal = 1'b0;
        fg_signal    = 1'b0;
        wire_signal  = 1'b0;
        test_reset();
        for (int k = 0; k < 4; k++) begin
            do_reset();
            test_shot(int'($urandom_range(0, WT - 1)), "nominal");
        end
        do_reset();
        test_shot(WT, "wire_at_timeout");
        do_reset();
        test_shot(0, "wire_first_cycle");
        do_reset();
        test_timeout();
        do_reset();
        test_abort();
        do_reset();
        test_reset_mid_shot();
        do_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter FG_DELAY, default 10_000_000: cycles from the function-generator rising edge to the detonation pulse; range 1..2^32-1.
REQ-002 Parameter DETECTOR_DELAY, default 5: cycles from the wire-trigger rising edge to the detector pulse; range 1..2^32-1.
REQ-003 Parameter WIRE_TIMEOUT, default 350_000: maximum cycles spent waiting for the wire edge after the detonation pulse ends; range 1..2^32-1.
REQ-004 Parameter PULSE_W, default 50: width in cycles of each output pulse; range 1..255.
REQ-005 Port CLOCK_50, input, 1 bit: the single 50 MHz clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port start_signal, input, 1 bit: level; arms a shot when sampled high in IDLE.
REQ-008 Port abort_signal, input, 1 bit: level; cancels any shot in progress.
REQ-009 Port fg_signal, input, 1 bit: asynchronous input from the function generator.
REQ-010 Port wire_signal, input, 1 bit: asynchronous input from the wire trigger.
REQ-011 Port detonation_signal, output, 1 bit: registered detonation pulse.
REQ-012 Port detector_signal, output, 1 bit: registered detector pulse.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE and FAULT.
REQ-014 Port done, output, 1 bit: one-cycle strobe when a shot completes.
REQ-015 Port fault, output, 1 bit: high while in FAULT.
REQ-016 Port state_code, output, 3 bits: encoding of the current state.

Function
REQ-017 The states SHALL be IDLE=0, ARMED=1, FG_WAIT_DLY=2, DETONATE=3, WIRE_WAIT=4, DET_WAIT_DLY=5, DET_PULSE=6, FAULT=7.
REQ-018 fg_signal and wire_signal SHALL each pass through a 2-flop synchronizer, then a registered rising-edge detector; the resulting internal strobe fg_rise / wire_rise is high 3 cycles after the pin rises.
REQ-019 IDLE SHALL go to ARMED when start_signal=1; ARMED SHALL go to FG_WAIT_DLY in the cycle after fg_rise.
REQ-020 fg_rise and wire_rise SHALL be ignored in every state except ARMED and WIRE_WAIT respectively.
REQ-021 There SHALL be one 32-bit counter, cleared on every state entry; it never wraps, because every comparison terminates at or below its parameter value.
REQ-022 If fg_rise is high in cycle t, detonation_signal SHALL rise in cycle t+FG_DELAY+1 and stay high for exactly PULSE_W cycles (state DETONATE).
REQ-023 After DETONATE the block SHALL enter WIRE_WAIT.
REQ-024 In WIRE_WAIT, wire_rise SHALL move the block to DET_WAIT_DLY.
REQ-025 If WIRE_TIMEOUT cycles elapse in WIRE_WAIT without wire_rise, the block SHALL move to FAULT.
REQ-026 If wire_rise arrives in the same cycle the timeout expires, wire_rise SHALL win.
REQ-027 If wire_rise is high in cycle w, detector_signal SHALL rise in cycle w+DETECTOR_DELAY+1 and stay high for PULSE_W cycles (DET_PULSE).
REQ-028 At the end of DET_PULSE the block SHALL return to IDLE with done=1 for exactly that one cycle.
REQ-029 FAULT SHALL hold until start_signal is low and abort_signal is high, then return to IDLE; FAULT never re-arms directly.
REQ-030 abort_signal=1 in any state other than IDLE or FAULT SHALL force IDLE on the next edge, dropping both pulses in that same edge.
REQ-031 abort_signal SHALL take priority over every other transition.
REQ-032 A start_signal held high SHALL not re-arm until after done; it re-arms in the cycle following the done cycle.
REQ-033 detonation_signal and detector_signal SHALL never be high simultaneously.
REQ-034 Each of detonation_signal and detector_signal SHALL pulse at most once per shot.

Reset
REQ-035 While reset=1 at a clock edge, the block SHALL hold: state=IDLE, counter=0, synchronizer and edge flops=0, all outputs=0.
REQ-036 Reset asserted mid-shot SHALL cut any active pulse on that same edge.
REQ-037 The first edge-detect after reset SHALL not fire on an input that was already high during reset.

Structure
REQ-038 Package sync_pkg SHALL hold the state enum type and the default delay and width constants.
REQ-039 Sub-module edge_sync (2-flop synchronizer plus rising-edge detector, with reset) SHALL be instantiated once for fg_signal and once for wire_signal.

Verification
REQ-040 Nominal shot, parameters overridden to FG_DELAY=10, DETECTOR_DELAY=5, PULSE_W=4: start, then fg rise at pin cycle p, then wire rise -> detonation high on cycles p+14..p+17, detector 9 cycles after the wire pin edge, done one cycle after the detector pulse ends.
REQ-041 Timeout with WIRE_TIMEOUT=20 and no wire edge -> fault=1 21 cycles after the detonation pulse falls; state_code=7; abort with start low -> IDLE.
REQ-042 Abort issued mid-detonation pulse -> detonation_signal=0 and state_code=0 on the next edge; a later fg edge produces no pulse.
REQ-043 wire_rise in the exact timeout cycle -> DET_WAIT_DLY entered, no fault.
REQ-044 Reset during FG_WAIT_DLY with fg_signal held high -> idle outputs all 0; after re-arm no pulse until fg goes low then high.
REQ-045 Spurious fg edges during WIRE_WAIT and start held high throughout -> exactly one detonation pulse and one detector pulse per shot.
